// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and the IF/ID
// pipeline register, with redirect/flush/stall priority and halt on running off the end of memory.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               flush_i,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i,
   output logic [IMEM_AW-1:0] imem_addr_o,
   input  logic [31:0]        imem_data_i,
   output logic [31:0]        pc_o,
   output logic [31:0]        ifid_instr_o,
   output logic [31:0]        ifid_pc4_o,
   output logic               ifid_valid_o,
   output logic               halted_o,
   output logic               misalign_o
);

   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] pc4_reg, pc4_next;
   logic        valid_reg, valid_next;
   logic        halted_reg, halted_next;
   logic        misalign_reg, misalign_next;
   logic [31:0] pc_plus4;
   logic        out_of_range;

   assign pc_plus4     = pc_reg + 32'd4;
   // Any PC bit above the word-address field means the fetch is past the end of memory.
   assign out_of_range = (pc_reg >> (IMEM_AW + 2)) != 32'd0;

   always_comb begin
      pc_next       = pc_reg;
      instr_next    = instr_reg;
      pc4_next      = pc4_reg;
      valid_next    = valid_reg;
      halted_next   = halted_reg;
      misalign_next = misalign_reg;
      if (redirect_i) begin
         pc_next     = {redirect_pc_i[31:2], 2'b00};
         instr_next  = 32'd0;
         pc4_next    = 32'd0;
         valid_next  = 1'b0;
         halted_next = 1'b0;
         if (redirect_pc_i[1:0] != 2'b00) begin
            misalign_next = 1'b1;
         end
      end else if (flush_i) begin
         instr_next = 32'd0;
         pc4_next   = 32'd0;
         valid_next = 1'b0;
      end else if (stall_i) begin
         pc_next = pc_reg;
      end else if (out_of_range || halted_reg) begin
         instr_next  = 32'd0;
         pc4_next    = 32'd0;
         valid_next  = 1'b0;
         halted_next = 1'b1;
      end else begin
         pc_next    = pc_plus4;
         instr_next = imem_data_i;
         pc4_next   = pc_plus4;
         valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_reg       <= RESET_PC;
         instr_reg    <= 32'd0;
         pc4_reg      <= 32'd0;
         valid_reg    <= 1'b0;
         halted_reg   <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         pc_reg       <= pc_next;
         instr_reg    <= instr_next;
         pc4_reg      <= pc4_next;
         valid_reg    <= valid_next;
         halted_reg   <= halted_next;
         misalign_reg <= misalign_next;
      end
   end

   assign imem_addr_o  = pc_reg[IMEM_AW+1:2];
   assign pc_o         = pc_reg;
   assign ifid_instr_o = instr_reg;
   assign ifid_pc4_o   = pc4_reg;
   assign ifid_valid_o = valid_reg;
   assign halted_o     = halted_reg;
   assign misalign_o   = misalign_reg;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: one full-size instance and one with a 4-word memory for the halt case.
module tb_if_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halted;
      logic        misalign;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;

   logic [7:0]  imem_addr1;
   logic [31:0] imem_data1, pc1, instr1, pc4_1;
   logic        valid1, halted1, mis1;
   logic [1:0]  imem_addr2;
   logic [31:0] imem_data2, pc2, instr2, pc4_2;
   logic        valid2, halted2, mis2;

   logic [31:0] mem1 [0:255];
   logic [31:0] mem2 [0:3];

   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   assign imem_data1 = mem1[imem_addr1];
   assign imem_data2 = mem2[imem_addr2];

   if_stage dut (
      .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .imem_addr_o(imem_addr1), .imem_data_i(imem_data1), .pc_o(pc1),
      .ifid_instr_o(instr1), .ifid_pc4_o(pc4_1), .ifid_valid_o(valid1),
      .halted_o(halted1), .misalign_o(mis1)
   );

   if_stage #(.IMEM_AW(2)) dut_small (
      .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .imem_addr_o(imem_addr2), .imem_data_i(imem_data2), .pc_o(pc2),
      .ifid_instr_o(instr2), .ifid_pc4_o(pc4_2), .ifid_valid_o(valid2),
      .halted_o(halted2), .misalign_o(mis2)
   );

   function automatic exp_t mk(logic [31:0] p, logic [31:0] i, logic [31:0] p4,
                               logic v, logic h, logic m);
      exp_t e;
      e.pc = p; e.instr = i; e.pc4 = p4; e.valid = v; e.halted = h; e.misalign = m;
      return e;
   endfunction

   function automatic exp_t obs1();
      return mk(pc1, instr1, pc4_1, valid1, halted1, mis1);
   endfunction

   function automatic exp_t obs2();
      return mk(pc2, instr2, pc4_2, valid2, halted2, mis2);
   endfunction

   function automatic logic [31:0] w1(int k);
      return 32'h2000_0000 + k;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ctl(logic s, logic f, logic r, logic [31:0] rp);
      stall = s; flush = f; redirect = r; redirect_pc = rp;
   endtask

   task automatic do_reset();
      set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Plain fetch edges that are not themselves checked.
   task automatic run(int n);
      set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      exp_t e, got;
      #1;
      q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_initial got=%h exp=%h", got, e); end
      tick();
      q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_held got=%h exp=%h", got, e); end
      $display("test_reset done");
   endtask

   task automatic test_fetch();
      exp_t e, got;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
         q.push_back(mk(32'(4*k), w1(k-1), 32'(4*k), 1'b1, 1'b0, 1'b0));
         tick();
         e = q.pop_front(); got = obs1(); checks++;
         if (got !== e) begin errors++; $display("FAIL fetch[%0d] got=%h exp=%h", k, got, e); end
      end
      $display("test_fetch done");
   endtask

   task automatic test_stall();
      exp_t e, got;
      do_reset();
      run(2);
      for (int k = 0; k < 2; k++) begin
         set_ctl(1'b1, 1'b0, 1'b0, 32'd0);
         q.push_back(mk(32'd8, w1(1), 32'd8, 1'b1, 1'b0, 1'b0));
         tick();
         e = q.pop_front(); got = obs1(); checks++;
         if (got !== e) begin errors++; $display("FAIL stall[%0d] got=%h exp=%h", k, got, e); end
      end
      set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
      q.push_back(mk(32'd12, w1(2), 32'd12, 1'b1, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL stall_release got=%h exp=%h", got, e); end
      $display("test_stall done");
   endtask

   task automatic test_redirect();
      exp_t e, got;
      for (int s = 0; s < 2; s++) begin
         do_reset();
         run(4);
         set_ctl(s[0], 1'b0, 1'b1, 32'h40);
         q.push_back(mk(32'h40, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
         tick();
         e = q.pop_front(); got = obs1(); checks++;
         if (got !== e) begin errors++; $display("FAIL redirect_stall%0d got=%h exp=%h", s, got, e); end
         set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
         q.push_back(mk(32'h44, w1(16), 32'h44, 1'b1, 1'b0, 1'b0));
         tick();
         e = q.pop_front(); got = obs1(); checks++;
         if (got !== e) begin errors++; $display("FAIL redirect_next_stall%0d got=%h exp=%h", s, got, e); end
      end
      $display("test_redirect done");
   endtask

   task automatic test_flush();
      exp_t e, got;
      do_reset();
      run(2);
      set_ctl(1'b1, 1'b1, 1'b0, 32'd0);
      q.push_back(mk(32'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL flush_with_stall got=%h exp=%h", got, e); end
      set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
      q.push_back(mk(32'd12, w1(2), 32'd12, 1'b1, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL flush_resume got=%h exp=%h", got, e); end
      $display("test_flush done");
   endtask

   task automatic test_misalign();
      exp_t e, got;
      do_reset();
      run(1);
      set_ctl(1'b0, 1'b0, 1'b1, 32'h23);
      q.push_back(mk(32'h20, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1));
      tick();
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL misalign_redirect got=%h exp=%h", got, e); end
      for (int k = 1; k <= 3; k++) begin
         set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
         q.push_back(mk(32'h20 + 32'(4*k), w1(7+k), 32'h20 + 32'(4*k), 1'b1, 1'b0, 1'b1));
         tick();
         e = q.pop_front(); got = obs1(); checks++;
         if (got !== e) begin errors++; $display("FAIL misalign_sticky[%0d] got=%h exp=%h", k, got, e); end
      end
      rst_n = 1'b0;
      #1;
      q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL misalign_cleared got=%h exp=%h", got, e); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("test_misalign done");
   endtask

   task automatic test_end_of_mem();
      exp_t e, got;
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
         if (k <= 4)
            q.push_back(mk(32'(4*k), 32'h3000_0000 + 32'(k-1), 32'(4*k), 1'b1, 1'b0, 1'b0));
         else
            q.push_back(mk(32'd16, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0));
         tick();
         e = q.pop_front(); got = obs2(); checks++;
         if (got !== e) begin errors++; $display("FAIL end_of_mem[%0d] got=%h exp=%h", k, got, e); end
      end
      set_ctl(1'b0, 1'b0, 1'b1, 32'd0);
      q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); got = obs2(); checks++;
      if (got !== e) begin errors++; $display("FAIL halt_redirect got=%h exp=%h", got, e); end
      set_ctl(1'b0, 1'b0, 1'b0, 32'd0);
      q.push_back(mk(32'd4, 32'h3000_0000, 32'd4, 1'b1, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); got = obs2(); checks++;
      if (got !== e) begin errors++; $display("FAIL halt_resume got=%h exp=%h", got, e); end
      $display("test_end_of_mem done");
   endtask

   task automatic test_async_reset();
      exp_t e, got;
      do_reset();
      run(6);
      q.push_back(mk(32'd24, w1(5), 32'd24, 1'b1, 1'b0, 1'b0));
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL pre_async got=%h exp=%h", got, e); end
      #2 rst_n = 1'b0;
      #1;
      q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0));
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, e); end
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back(mk(32'd4, w1(0), 32'd4, 1'b1, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); got = obs1(); checks++;
      if (got !== e) begin errors++; $display("FAIL after_async got=%h exp=%h", got, e); end
      $display("test_async_reset done");
   endtask

   initial begin
      for (int k = 0; k < 256; k++) mem1[k] = 32'h2000_0000 + 32'(k);
      for (int k = 0; k < 4; k++)   mem2[k] = 32'h3000_0000 + 32'(k);
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_flush();
      test_misalign();
      test_end_of_mem();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
